// File: rtl/dso_pkg.sv
// Shared types and defaults for the acquisition control path.
package dso_pkg;

    // Default sample RAM address width (DEPTH = 2**ADDR_W entries).
    localparam int ADDR_W_DEFAULT = 9;

    // Acquisition sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } capture_state_t;

endpackage

// File: rtl/capture_ctrl_wrap_ptr.sv
// Modulo-2**W pointer with synchronous clear and increment enable.
// Clear wins over increment; the natural binary wrap gives DEPTH-1 -> 0.
module wrap_ptr #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Pointer register: reset/clear to zero, otherwise step on inc.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Acquisition sequencer: fills the circular sample RAM with pre-trigger
// history, arms the trigger detector, collects the programmed number of
// post-trigger samples and then holds the buffer until the host acks it.
//
// Interface semantics: smpl is a one-cycle strobe and every strobe seen in
// PRE/ARMED/POST is written (we is combinational from smpl); there is no
// back-pressure. triggered is a sticky level owned by the detector and is
// cleared by the one-cycle set_capture_done pulse. capture_en is a level
// run request; capture_ack is a level/pulse only honoured in DONE.
module capture_ctrl
    import dso_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_en,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              smpl,
    input  logic              triggered,
    input  logic              capture_ack,
    output logic              armed,
    output logic              set_capture_done,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              capture_done,
    output logic              busy
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;

    capture_state_t state, next_state;

    // Counters are one bit wider than the address so DEPTH is representable.
    logic [CNT_W-1:0] pre_cnt;
    logic [CNT_W-1:0] post_cnt;
    logic [CNT_W-1:0] tp_q;
    logic [CNT_W-1:0] pre_target;
    logic [CNT_W-1:0] pre_cnt_nxt;
    logic [CNT_W-1:0] post_cnt_nxt;
    logic             done_pulse;

    // Strobes from the next-state logic into the datapath registers.
    logic start_run;
    logic pre_inc;
    logic post_inc;
    logic trig_latch;

    // Pre-trigger history needed before arming: the rest of the buffer.
    assign pre_target   = CNT_W'(DEPTH) - tp_q;
    assign pre_cnt_nxt  = pre_cnt + 1'b1;
    assign post_cnt_nxt = post_cnt + 1'b1;

    // Writes happen on any strobe while an acquisition is running.
    assign we = smpl && ((state == PRE) || (state == ARMED) || (state == POST));

    wrap_ptr #(
        .W (ADDR_W)
    ) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (start_run),
        .inc (we),
        .ptr (waddr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        next_state = state;
        start_run  = 1'b0;
        pre_inc    = 1'b0;
        post_inc   = 1'b0;
        trig_latch = 1'b0;
        case (state)
            IDLE: begin
                if (capture_en) begin
                    next_state = PRE;
                    start_run  = 1'b1;
                end
            end
            PRE: begin
                if (!capture_en) begin
                    next_state = IDLE;
                end else if (smpl) begin
                    pre_inc = 1'b1;
                    if (pre_cnt_nxt == pre_target) begin
                        next_state = ARMED;
                    end
                end
            end
            ARMED: begin
                if (!capture_en) begin
                    next_state = IDLE;
                end else if (triggered) begin
                    trig_latch = 1'b1;
                    // A coincident write is already post sample 1.
                    if (tp_q == '0) begin
                        next_state = DONE;
                    end else if (smpl && (tp_q == CNT_W'(1))) begin
                        next_state = DONE;
                    end else begin
                        next_state = POST;
                    end
                end
            end
            POST: begin
                if (!capture_en) begin
                    next_state = IDLE;
                end else if (smpl) begin
                    post_inc = 1'b1;
                    if (post_cnt_nxt == tp_q) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (capture_ack) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Counters, latched post-trigger length and trigger address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt   <= '0;
            post_cnt  <= '0;
            tp_q      <= '0;
            trig_addr <= '0;
        end else begin
            if (start_run) begin
                pre_cnt <= '0;
                tp_q    <= {1'b0, trig_pos};
            end else if (pre_inc) begin
                pre_cnt <= pre_cnt_nxt;
            end
            if (trig_latch) begin
                trig_addr <= waddr;
                post_cnt  <= smpl ? CNT_W'(1) : '0;
            end else if (post_inc) begin
                post_cnt <= post_cnt_nxt;
            end
        end
    end

    // One-cycle completion pulse, registered on entry into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= (next_state == DONE) && (state != DONE);
        end
    end

    assign armed            = (state == ARMED);
    assign busy             = (state == PRE) || (state == ARMED) || (state == POST);
    assign capture_done     = (state == DONE);
    assign set_capture_done = done_pulse;

endmodule

// File: tb/tb_capture_ctrl.sv
// Testbench for capture_ctrl with ADDR_W=4 (DEPTH=16). A cycle-level
// reference model built from write counts (history written, post samples
// written) predicts every output; directed scenario tasks add their own
// targeted checks, followed by a randomized run.
module tb_capture_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          capture_en;
    logic [AW-1:0] trig_pos;
    logic          smpl;
    logic          triggered;
    logic          capture_ack;
    logic          armed;
    logic          set_capture_done;
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] trig_addr;
    logic          capture_done;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Reference model: acquisition described by counts of writes.
    bit m_running   = 1'b0;
    bit m_done      = 1'b0;
    bit m_trig_seen = 1'b0;
    bit m_pulse     = 1'b0;
    int m_pre       = 0;
    int m_post      = 0;
    int m_ptr       = 0;
    int m_trig_addr = 0;
    int m_tp        = 0;

    capture_ctrl #(
        .ADDR_W (AW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .capture_en       (capture_en),
        .trig_pos         (trig_pos),
        .smpl             (smpl),
        .triggered        (triggered),
        .capture_ack      (capture_ack),
        .armed            (armed),
        .set_capture_done (set_capture_done),
        .we               (we),
        .waddr            (waddr),
        .trig_addr        (trig_addr),
        .capture_done     (capture_done),
        .busy             (busy)
    );

    // Clock.
    always #5 clk = ~clk;

    // Armed once enough history exists to leave room for tp post samples.
    function automatic bit exp_armed();
        return m_running && !m_trig_seen && (m_pre >= DEPTH - m_tp);
    endfunction

    // Model update on every rising edge from the inputs held that cycle.
    always @(posedge clk) begin : model
        bit wr;
        bit arm_now;
        wr      = m_running && smpl;
        arm_now = exp_armed();
        if (rst) begin
            m_running = 0; m_done = 0; m_trig_seen = 0; m_pulse = 0;
            m_pre = 0; m_post = 0; m_ptr = 0; m_trig_addr = 0; m_tp = 0;
        end else if (m_done) begin
            m_pulse = 0;
            if (capture_ack) m_done = 0;
        end else if (!m_running) begin
            m_pulse = 0;
            if (capture_en) begin
                m_running = 1; m_ptr = 0; m_pre = 0; m_post = 0;
                m_trig_seen = 0; m_tp = int'(trig_pos);
            end
        end else begin
            m_pulse = 0;
            if (capture_en) begin
                if (arm_now && triggered) begin
                    m_trig_seen = 1;
                    m_trig_addr = m_ptr;
                    m_post      = wr ? 1 : 0;
                end else if (wr && m_trig_seen) begin
                    m_post++;
                end else if (wr) begin
                    m_pre++;
                end
                if (m_trig_seen && m_post >= m_tp) begin
                    m_running = 0; m_done = 1; m_pulse = 1;
                end
            end else begin
                m_running = 0;
            end
            if (wr) m_ptr = (m_ptr + 1) % DEPTH;
        end
    end

    // Scoreboard: compare every output with the model mid-cycle.
    always @(negedge clk) begin : monitor
        logic [AW-1:0] e_waddr;
        logic [AW-1:0] e_taddr;
        if (chk_en) begin
            e_waddr = AW'(m_ptr);
            e_taddr = AW'(m_trig_addr);
            vectors++;
            if (armed !== exp_armed()) begin
                miscompares++;
                $display("FAIL armed @%0t: got %b want %b", $time, armed, exp_armed());
            end
            if (busy !== m_running) begin
                miscompares++;
                $display("FAIL busy @%0t: got %b want %b", $time, busy, m_running);
            end
            if (capture_done !== m_done) begin
                miscompares++;
                $display("FAIL capture_done @%0t: got %b want %b", $time, capture_done, m_done);
            end
            if (set_capture_done !== m_pulse) begin
                miscompares++;
                $display("FAIL set_capture_done @%0t: got %b want %b", $time, set_capture_done, m_pulse);
            end
            if (we !== (m_running && smpl)) begin
                miscompares++;
                $display("FAIL we @%0t: got %b want %b", $time, we, m_running && smpl);
            end
            if (waddr !== e_waddr) begin
                miscompares++;
                $display("FAIL waddr @%0t: got %0d want %0d", $time, waddr, e_waddr);
            end
            if (trig_addr !== e_taddr) begin
                miscompares++;
                $display("FAIL trig_addr @%0t: got %0d want %0d", $time, trig_addr, e_taddr);
            end
        end
    end

    // Advance n clock cycles, landing 1 time unit after the edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        capture_en  = 1'b0;
        smpl        = 1'b0;
        triggered   = 1'b0;
        capture_ack = 1'b0;
        trig_pos    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cyc(2);
        rst = 1'b0;
    endtask

    // Start a run and wait (bounded) for armed, counting writes on the way.
    task automatic run_to_armed(input int tp, input int period, input int exp_writes);
        int n;
        int nw;
        n  = 0;
        nw = 0;
        trig_pos   = AW'(tp);
        capture_en = 1'b1;
        smpl       = 1'b0;
        cyc(1);
        while (armed !== 1'b1 && n < 400) begin
            smpl = ((n % period) == 0);
            #1;
            if (we === 1'b1) nw++;
            cyc(1);
            n++;
        end
        smpl = 1'b0;
        vectors++;
        if (armed !== 1'b1 || nw != exp_writes) begin
            miscompares++;
            $display("FAIL writes_to_armed tp=%0d: got %0d writes (armed=%b) want %0d", tp, nw, armed, exp_writes);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        capture_en  = 1'b1;
        smpl        = 1'b1;
        triggered   = 1'b1;
        capture_ack = 1'b1;
        trig_pos    = 4'd3;
        cyc(2);
        vectors++;
        if ({armed, set_capture_done, capture_done, busy} !== 4'b0000 || waddr !== 4'd0 || trig_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: got armed=%b scd=%b done=%b busy=%b waddr=%0d taddr=%0d want all 0",
                     armed, set_capture_done, capture_done, busy, waddr, trig_addr);
        end
        smpl = 1'b0;
        vectors++;
        #1;
        if (we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_we: got %b want 0", we);
        end
        idle_inputs();
        cyc(1);
        rst    = 1'b0;
        chk_en = 1'b1;
        cyc(2);
    endtask

    task automatic test_normal();
        int exp_w;
        int n;
        int nw;
        int pulses;
        run_to_armed(4, 1, 12);
        smpl = 1'b1;
        cyc(20);
        exp_w     = m_ptr;
        triggered = 1'b1;
        n = 0; nw = 0; pulses = 0;
        while (capture_done !== 1'b1 && n < 40) begin
            #1;
            if (we === 1'b1) nw++;
            cyc(1);
            n++;
        end
        vectors++;
        if (nw != 4) begin
            miscompares++;
            $display("FAIL normal_post_writes: got %0d want 4", nw);
        end
        vectors++;
        if (trig_addr !== AW'(exp_w)) begin
            miscompares++;
            $display("FAIL normal_trig_addr: got %0d want %0d", trig_addr, exp_w);
        end
        for (int i = 0; i < 4; i++) begin
            if (set_capture_done === 1'b1) pulses++;
            if (i == 0) triggered = 1'b0;
            cyc(1);
        end
        vectors++;
        if (pulses != 1 || capture_done !== 1'b1) begin
            miscompares++;
            $display("FAIL normal_done_pulse: got %0d pulses done=%b want 1 pulse done=1", pulses, capture_done);
        end
        smpl        = 1'b0;
        capture_en  = 1'b0;
        capture_ack = 1'b1;
        cyc(1);
        capture_ack = 1'b0;
        vectors++;
        if (capture_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL normal_ack: got done=%b busy=%b want 0 0", capture_done, busy);
        end
        cyc(2);
    endtask

    task automatic test_sparse();
        int n;
        int nstrobe;
        run_to_armed(2, 3, 14);
        cyc(5);
        triggered = 1'b1;
        n = 0; nstrobe = 0;
        while (capture_done !== 1'b1 && n < 40) begin
            smpl = ((n % 3) == 2);
            #1;
            if (we === 1'b1) nstrobe++;
            cyc(1);
            n++;
        end
        smpl = 1'b0;
        vectors++;
        if (nstrobe != 2 || n != 6) begin
            miscompares++;
            $display("FAIL sparse_post: got %0d strobes in %0d cycles want 2 in 6", nstrobe, n);
        end
        triggered   = 1'b0;
        capture_en  = 1'b0;
        capture_ack = 1'b1;
        cyc(1);
        capture_ack = 1'b0;
        cyc(2);
    endtask

    task automatic test_tp0();
        int exp_w;
        run_to_armed(0, 1, 16);
        cyc(3);
        exp_w     = m_ptr;
        smpl      = 1'b1;
        triggered = 1'b1;
        cyc(1);
        smpl      = 1'b0;
        vectors++;
        if (capture_done !== 1'b1 || set_capture_done !== 1'b1 || trig_addr !== AW'(exp_w)
            || waddr !== AW'((exp_w + 1) % DEPTH)) begin
            miscompares++;
            $display("FAIL tp0_done: got done=%b scd=%b taddr=%0d waddr=%0d want 1 1 %0d %0d",
                     capture_done, set_capture_done, trig_addr, waddr, exp_w, (exp_w + 1) % DEPTH);
        end
        triggered = 1'b0;
        cyc(1);
        vectors++;
        if (set_capture_done !== 1'b0) begin
            miscompares++;
            $display("FAIL tp0_pulse_width: got %b want 0", set_capture_done);
        end
        capture_en  = 1'b0;
        capture_ack = 1'b1;
        cyc(1);
        capture_ack = 1'b0;
        cyc(1);
    endtask

    task automatic test_abort();
        int hold_w;
        run_to_armed(8, 1, 8);
        smpl      = 1'b1;
        triggered = 1'b1;
        cyc(3);
        smpl       = 1'b0;
        triggered  = 1'b0;
        hold_w     = m_ptr;
        capture_en = 1'b0;
        cyc(1);
        vectors++;
        if (busy !== 1'b0 || set_capture_done !== 1'b0 || capture_done !== 1'b0 || waddr !== AW'(hold_w)) begin
            miscompares++;
            $display("FAIL abort_post: got busy=%b scd=%b done=%b waddr=%0d want 0 0 0 %0d",
                     busy, set_capture_done, capture_done, waddr, hold_w);
        end
        cyc(2);
        run_to_armed(5, 1, 11);
        smpl = 1'b1;
        cyc(7);
        rst = 1'b1;
        cyc(1);
        vectors++;
        if ({armed, set_capture_done, capture_done, busy, we} !== 5'b00000 || waddr !== 4'd0 || trig_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL rst_armed: got armed=%b scd=%b done=%b busy=%b we=%b waddr=%0d taddr=%0d want all 0",
                     armed, set_capture_done, capture_done, busy, we, waddr, trig_addr);
        end
        rst = 1'b0;
        idle_inputs();
        cyc(2);
    endtask

    task automatic test_ignore();
        int n;
        run_to_armed(4, 1, 12);
        capture_ack = 1'b1;
        cyc(3);
        capture_ack = 1'b0;
        vectors++;
        if (armed !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_in_armed: got armed=%b want 1", armed);
        end
        smpl      = 1'b1;
        triggered = 1'b1;
        n = 0;
        while (capture_done !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        triggered = 1'b0;
        smpl      = 1'b1;
        cyc(5);
        vectors++;
        if (capture_done !== 1'b1 || busy !== 1'b0 || we !== 1'b0) begin
            miscompares++;
            $display("FAIL en_in_done: got done=%b busy=%b we=%b want 1 0 0", capture_done, busy, we);
        end
        smpl        = 1'b0;
        capture_ack = 1'b1;
        cyc(1);
        capture_ack = 1'b0;
        cyc(1);
        vectors++;
        if (busy !== 1'b1 || waddr !== 4'd0) begin
            miscompares++;
            $display("FAIL restart_after_ack: got busy=%b waddr=%0d want 1 0", busy, waddr);
        end
        capture_en = 1'b0;
        cyc(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            capture_en  = ($urandom_range(0, 39) != 0);
            smpl        = ($urandom_range(0, 2) != 0);
            triggered   = ($urandom_range(0, 9) == 0);
            capture_ack = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) trig_pos = AW'($urandom_range(0, DEPTH - 1));
            cyc(1);
        end
        rst = 1'b0;
        idle_inputs();
        cyc(2);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_normal();
        test_sparse();
        test_tp0();
        test_abort();
        test_ignore();
        test_random();
        do_reset();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
